// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register rename state
// (ROB tag + busy flag) for an out-of-order core.
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous active-high reset, clears all state
//   rdy        in   global enable; low freezes state (reads stay live)
//   rd_idx     in   NRD*AW read indices, port p at [p*AW +: AW]
//   rd_value   out  NRD*DW register value per port (with commit bypass)
//   rd_tag     out  NRD*TW ROB tag per port
//   rd_busy    out  NRD    busy flag per port (with commit bypass)
//   ren_valid  in   rename request
//   ren_idx    in   destination register to rename
//   ren_tag    in   ROB tag assigned to the destination
//   cmt_valid  in   ROB commit
//   cmt_idx    in   committed destination register
//   cmt_tag    in   committing ROB tag
//   cmt_value  in   committed result
//   flush      in   mispredict flush, clears every busy flag
//   busy_cnt   out  registered count of busy registers
module regfile_rename #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int TW   = 4,
    parameter int NRD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [NRD*AW-1:0] rd_idx,
    output logic [NRD*DW-1:0] rd_value,
    output logic [NRD*TW-1:0] rd_tag,
    output logic [NRD-1:0]    rd_busy,
    input  logic              ren_valid,
    input  logic [AW-1:0]     ren_idx,
    input  logic [TW-1:0]     ren_tag,
    input  logic              cmt_valid,
    input  logic [AW-1:0]     cmt_idx,
    input  logic [TW-1:0]     cmt_tag,
    input  logic [DW-1:0]     cmt_value,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);

    logic [DW-1:0]   value_q [NREG];
    logic [DW-1:0]   value_d [NREG];
    logic [TW-1:0]   tag_q   [NREG];
    logic [TW-1:0]   tag_d   [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     busy_cnt_d;

    logic cmt_wr_s;
    logic cmt_clr_s;
    logic ren_wr_s;

    // Decode which update paths fire this cycle; x0 is never written.
    always_comb begin
        cmt_wr_s  = cmt_valid && (cmt_idx != {AW{1'b0}});
        cmt_clr_s = cmt_wr_s && busy_q[cmt_idx] && (tag_q[cmt_idx] == cmt_tag);
        ren_wr_s  = ren_valid && (ren_idx != {AW{1'b0}}) && !flush;
    end

    // Next-state: commit first, then rename, so a same-register rename
    // leaves the register busy under the new tag while the value is written.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (cmt_wr_s) begin
            value_d[cmt_idx] = cmt_value;
        end else begin
            value_d[0] = value_q[0];
        end
        if (cmt_clr_s) begin
            busy_d[cmt_idx] = 1'b0;
        end else begin
            busy_d[0] = busy_q[0];
        end
        if (flush) begin
            busy_d = {NREG{1'b0}};
        end else if (ren_wr_s) begin
            busy_d[ren_idx] = 1'b1;
            tag_d[ren_idx]  = ren_tag;
        end else begin
            busy_d[0] = busy_q[0];
        end
    end

    // Busy count is the population count of the next busy vector, so it is
    // exact after every edge and bounded by NREG-1 (x0 is never busy).
    always_comb begin
        busy_cnt_d = {(AW+1){1'b0}};
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // State registers: reset dominates, rdy low holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= {DW{1'b0}};
                tag_q[i]   <= {TW{1'b0}};
            end
            busy_q     <= {NREG{1'b0}};
            busy_cnt_q <= {(AW+1){1'b0}};
        end else if (rdy) begin
            value_q    <= value_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] idx_s;
        logic          byp_s;
        assign idx_s = rd_idx[p*AW +: AW];
        assign byp_s = cmt_valid && (cmt_idx == idx_s) && busy_q[idx_s]
                       && (tag_q[idx_s] == cmt_tag);

        // Combinational read with same-cycle commit bypass; x0 reads zero.
        always_comb begin
            if (idx_s == {AW{1'b0}}) begin
                rd_value[p*DW +: DW] = {DW{1'b0}};
                rd_tag[p*TW +: TW]   = {TW{1'b0}};
                rd_busy[p]           = 1'b0;
            end else if (byp_s) begin
                rd_value[p*DW +: DW] = cmt_value;
                rd_tag[p*TW +: TW]   = tag_q[idx_s];
                rd_busy[p]           = 1'b0;
            end else begin
                rd_value[p*DW +: DW] = value_q[idx_s];
                rd_tag[p*TW +: TW]   = tag_q[idx_s];
                rd_busy[p]           = busy_q[idx_s];
            end
        end
    end

endmodule

// File: doc/regfile_rename.md
REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers (power of two, >=2).
REQ-002 SHALL have parameter AW, default 5, register index width = log2(NREG).
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter TW, default 4, ROB tag width.
REQ-005 SHALL have parameter NRD, default 2, number of decode read ports (1..4).
REQ-006 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-009 SHALL have port rd_idx  input  NRD*AW  read indices, port p at bits [p*AW +: AW].
REQ-010 SHALL have port rd_value  output  NRD*DW  per-port register value.
REQ-011 SHALL have port rd_tag  output  NRD*TW  per-port ROB tag.
REQ-012 SHALL have port rd_busy  output  NRD  per-port busy flag.
REQ-013 SHALL have port ren_valid  input  1  rename request this cycle.
REQ-014 SHALL have port ren_idx  input  AW  destination register to rename.
REQ-015 SHALL have port ren_tag  input  TW  ROB tag assigned to the destination.
REQ-016 SHALL have port cmt_valid  input  1  ROB commit this cycle.
REQ-017 SHALL have port cmt_idx  input  AW  committed destination register.
REQ-018 SHALL have port cmt_tag  input  TW  committing ROB tag.
REQ-019 SHALL have port cmt_value  input  DW  committed result.
REQ-020 SHALL have port flush  input  1  mispredict flush; clears all speculative renames.
REQ-021 SHALL have port busy_cnt  output  AW+1  registered count of busy registers.

Function
REQ-022 Per register i, state SHALL be value[i] (DW), tag[i] (TW), busy[i] (1).
REQ-023 Register 0 SHALL read value 0, tag 0, busy 0 on every port and SHALL ignore every write.
REQ-024 Reads SHALL be combinational, zero latency, all NRD ports independent, including identical indices.
REQ-025 Commit bypass: if cmt_valid, cmt_idx==rd_idx!=0, busy[idx]=1 and tag[idx]==cmt_tag, the port SHALL show rd_value=cmt_value, rd_busy=0 in the same cycle.
REQ-026 Same-cycle rename SHALL NOT affect read outputs until the next cycle.
REQ-027 Commit (cmt_valid, cmt_idx!=0) SHALL write value[cmt_idx]<=cmt_value regardless of tag.
REQ-028 Commit SHALL clear busy[cmt_idx] only when tag[cmt_idx]==cmt_tag and busy[cmt_idx]=1; tag SHALL be unchanged.
REQ-029 Rename (ren_valid, ren_idx!=0, flush=0) SHALL set busy[ren_idx]<=1, tag[ren_idx]<=ren_tag.
REQ-030 Rename and commit to the same register in one cycle: value SHALL take cmt_value, busy SHALL end 1, tag SHALL end ren_tag.
REQ-031 flush=1 SHALL clear busy of every register next cycle, keep tags, and drop any same-cycle rename.
REQ-032 flush=1 with cmt_valid SHALL still perform the commit's value write.
REQ-033 busy_cnt SHALL equal the number of busy registers after each edge: +1 for a rename of a non-busy register, -1 for a matching clear, net 0 when both hit one register, 0 after flush.
REQ-034 busy_cnt SHALL never exceed NREG-1 nor underflow.
REQ-035 rdy=0 SHALL hold all state and busy_cnt; reads and bypass SHALL remain live.

Reset
REQ-036 rst=1 at a clock edge SHALL set every value, tag, busy and busy_cnt to 0, overriding rdy, flush, rename and commit.
REQ-037 Reset asserted mid-operation SHALL discard all pending renames; first post-reset cycle reads 0/0/0 on all ports.

Verification
REQ-038 Rename x5 tag 3, next cycle read x5 -> busy=1, tag=3, busy_cnt=1.
REQ-039 x5 busy tag 3, commit x5 tag 3 value 0xDEAD while reading x5 -> same cycle rd_value=0xDEAD, rd_busy=0; next cycle busy_cnt=0.
REQ-040 x5 renamed tag 3 then tag 7, commit tag 3 value 0x11 -> value=0x11, busy stays 1, tag=7, busy_cnt=1.
REQ-041 Rename x0 tag 2, commit x0 value 0xFF -> x0 reads 0/0/0, busy_cnt unchanged.
REQ-042 Rename x1,x2,x3; flush with simultaneous rename x4 and commit x2 value 0x42 -> all busy 0, x4 not busy, x2 value 0x42, busy_cnt=0.
REQ-043 Same cycle rename x9 tag 4 and commit x9 matching old tag value 0x7 -> value 0x7, busy 1, tag 4, busy_cnt unchanged.
